fractcam_upd_ctrl: RTL and testbench

//  Rule-update sequencer and search arbiter for the 32-entry, 5-bit-key fractional TCAM block (4 groups x 8 entries).

---
 rtl/fractcam_pkg.sv | 29 ++
 rtl/fractcam_prio_enc.sv | 22 ++
 rtl/fractcam_upd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fractcam_upd_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractcam_pkg.sv
// Shared definitions for the fractional TCAM update controller.
//   KW     key width (sweep length is 2**KW addresses)
//   DEPTH  number of rule entries
//   GROUP  entries per fractcam unit, NGRP groups in total
//   OP_*   update opcodes carried on upd_op
//   state_t controller FSM states
package fractcam_pkg;

   localparam int KW    = 5;
   localparam int DEPTH = 32;
   localparam int GROUP = 8;
   localparam int NGRP  = DEPTH / GROUP;
   localparam int IW    = $clog2(DEPTH);
   localparam int GW    = $clog2(NGRP);

   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_DELETE = 2'b01;
   localparam logic [1:0] OP_FLUSH  = 2'b10;
   localparam logic [1:0] OP_NOP    = 2'b11;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_LOAD  = 3'd2,
      S_SWEEP = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/fractcam_prio_enc.sv
// Lowest-index-wins priority encoder over the TCAM match vector.
//   match  in   DEPTH  per-entry match bits
//   hit    out  1      any bit set
//   idx    out  IW     index of lowest set bit, 0 when no bit is set
module fractcam_prio_enc
   import fractcam_pkg::*;
(
   input  logic [DEPTH-1:0] match,
   output logic             hit,
   output logic [IW-1:0]    idx
);

   // Scanning downwards lets the lowest set bit overwrite all higher ones.
   always_comb begin
      hit = |match;
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/fractcam_upd_ctrl.sv
// Rule-update sequencer and search arbiter for the 32-entry fractional TCAM.
// Keeps a shadow {valid,key,mask} table and rewrites one group's LUTs by
// sweeping every key address; shares the TCAM sk port with lookups.
//   wclk, rst_n          clock, synchronous active-low reset
//   upd_*                update request channel, upd_done pulses when written
//   srch_*               lookup request channel
//   rslt_*               lookup result strobe, hit flag and lowest index
//   busy                 init or update sweep in progress
//   tcam_*               registered drive to the TCAM, tcam_match back from it
//   dbg_state            current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on the same channel's valid, except that
// srch_ready drops while upd_valid is high so an update wins the port.
module fractcam_upd_ctrl
   import fractcam_pkg::*;
(
   input  logic              wclk,
   input  logic              rst_n,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [1:0]        upd_op,
   input  logic [IW-1:0]     upd_idx,
   input  logic [KW-1:0]     upd_key,
   input  logic [KW-1:0]     upd_mask,
   output logic              upd_done,
   input  logic              srch_valid,
   output logic              srch_ready,
   input  logic [KW-1:0]     srch_key,
   output logic              rslt_valid,
   output logic              rslt_hit,
   output logic [IW-1:0]     rslt_idx,
   output logic              busy,
   output logic [KW-1:0]     tcam_sk,
   output logic              tcam_clr,
   output logic [NGRP-1:0]   tcam_we,
   output logic [GROUP-1:0]  tcam_rules,
   input  logic [DEPTH-1:0]  tcam_match,
   output logic [2:0]        dbg_state
);

   state_t state, nxt;

   logic [KW-1:0]    cnt;
   logic [1:0]       op_q;
   logic [IW-1:0]    idx_q;
   logic [KW-1:0]    key_q, mask_q;
   logic [DEPTH-1:0] sh_valid;
   logic [KW-1:0]    sh_key  [DEPTH];
   logic [KW-1:0]    sh_mask [DEPTH];

   logic             upd_fire, srch_fire, srch_pend;
   logic [GW-1:0]    grp;
   logic             flush;
   logic [IW-1:0]    ent;
   logic [GROUP-1:0] rules_calc;
   logic [KW-1:0]    sk_d;
   logic [NGRP-1:0]  we_d;
   logic [GROUP-1:0] rules_d;
   logic             done_d;
   logic             enc_hit;
   logic [IW-1:0]    enc_idx;

   assign upd_ready  = (state == S_IDLE);
   assign srch_ready = upd_ready & ~upd_valid;
   assign upd_fire   = upd_ready & upd_valid;
   assign srch_fire  = srch_ready & srch_valid;
   // Held in reset the controller reports idle even though it sits in INIT.
   assign busy       = rst_n & (state != S_IDLE);
   assign tcam_clr   = 1'b0;
   assign dbg_state  = state;
   assign grp        = GW'(int'(idx_q) / GROUP);
   assign flush      = (op_q == OP_FLUSH);

   // ---------------- state register ----------------
   always_ff @(posedge wclk) begin
      if (!rst_n) state <= S_INIT;
      else        state <= nxt;
   end

   // ---------------- next state ----------------
   always_comb begin
      nxt = state;
      case (state)
         S_INIT:  if (cnt == '1) nxt = S_IDLE;
         S_IDLE:  if (upd_valid) nxt = (upd_op == OP_NOP) ? S_DONE : S_LOAD;
         S_LOAD:  nxt = S_SWEEP;
         S_SWEEP: if (cnt == '1) nxt = S_DONE;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_INIT;
      endcase
   end

   // LUT contents for the target group at sweep address cnt.
   always_comb begin
      rules_calc = '0;
      ent        = '0;
      for (int j = 0; j < GROUP; j++) begin
         ent = IW'(int'(grp) * GROUP + j);
         rules_calc[j] = sh_valid[ent] & (((cnt ^ sh_key[ent]) & sh_mask[ent]) == '0);
      end
   end

   // ---------------- outputs (registered below) ----------------
   // sk defaults to its held value so LOAD and idle cycles leave an
   // in-flight lookup address untouched.
   always_comb begin
      sk_d    = tcam_sk;
      we_d    = '0;
      rules_d = '0;
      done_d  = 1'b0;
      case (state)
         S_INIT: begin
            sk_d = cnt;
            we_d = '1;
         end
         S_IDLE: if (srch_fire) sk_d = srch_key;
         S_SWEEP: begin
            sk_d    = cnt;
            we_d    = flush ? '1 : (NGRP'(1) << grp);
            rules_d = flush ? '0 : rules_calc;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   fractcam_prio_enc u_enc (
      .match (tcam_match),
      .hit   (enc_hit),
      .idx   (enc_idx)
   );

   always_ff @(posedge wclk) begin
      if (!rst_n) begin
         cnt        <= '0;
         op_q       <= OP_NOP;
         idx_q      <= '0;
         key_q      <= '0;
         mask_q     <= '0;
         sh_valid   <= '0;
         tcam_sk    <= '0;
         tcam_we    <= '0;
         tcam_rules <= '0;
         upd_done   <= 1'b0;
         srch_pend  <= 1'b0;
         rslt_valid <= 1'b0;
         rslt_hit   <= 1'b0;
         rslt_idx   <= '0;
      end else begin
         // Sweep address; falls back to 0 outside INIT/SWEEP so each sweep starts at 0.
         cnt <= (state == S_INIT || state == S_SWEEP) ? cnt + 1'b1 : '0;
         if (upd_fire) begin
            op_q   <= upd_op;
            idx_q  <= upd_idx;
            key_q  <= upd_key;
            mask_q <= upd_mask;
         end
         if (state == S_LOAD) begin
            case (op_q)
               OP_WRITE:  sh_valid[idx_q] <= 1'b1;
               OP_DELETE: sh_valid[idx_q] <= 1'b0;
               OP_FLUSH:  sh_valid        <= '0;
               default:   ;
            endcase
         end
         tcam_sk    <= sk_d;
         tcam_we    <= we_d;
         tcam_rules <= rules_d;
         upd_done   <= done_d;
         // Match is sampled one edge after sk was driven with the search key.
         srch_pend  <= srch_fire;
         rslt_valid <= srch_pend;
         if (srch_pend) begin
            rslt_hit <= enc_hit;
            rslt_idx <= enc_idx;
         end
      end
   end

   // Key/mask only matter while valid is set, so they carry no reset.
   always_ff @(posedge wclk) begin
      if (rst_n && state == S_LOAD && op_q == OP_WRITE) begin
         sh_key[idx_q]  <= key_q;
         sh_mask[idx_q] <= mask_q;
      end
   end

endmodule

// File: tb/tb_fractcam_upd_ctrl.sv
// Bench for fractcam_upd_ctrl: a behavioural LUT-based TCAM closes the loop,
// a rule-list reference model predicts lookups, and a cycle-tagged expected
// queue checks every result strobe.
module tb_fractcam_upd_ctrl;
   import fractcam_pkg::*;

   // ---------------- clock / reset ----------------
   logic wclk = 1'b0;
   always #5 wclk = ~wclk;
   logic rst_n;

   logic              upd_valid, upd_ready, upd_done;
   logic [1:0]        upd_op;
   logic [IW-1:0]     upd_idx;
   logic [KW-1:0]     upd_key, upd_mask;
   logic              srch_valid, srch_ready;
   logic [KW-1:0]     srch_key;
   logic              rslt_valid, rslt_hit;
   logic [IW-1:0]     rslt_idx;
   logic              busy;
   logic [KW-1:0]     tcam_sk;
   logic              tcam_clr;
   logic [NGRP-1:0]   tcam_we;
   logic [GROUP-1:0]  tcam_rules;
   logic [DEPTH-1:0]  tcam_match;
   logic [2:0]        dbg_state;

   fractcam_upd_ctrl dut (
      .wclk(wclk), .rst_n(rst_n),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
      .upd_idx(upd_idx), .upd_key(upd_key), .upd_mask(upd_mask), .upd_done(upd_done),
      .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
      .rslt_valid(rslt_valid), .rslt_hit(rslt_hit), .rslt_idx(rslt_idx),
      .busy(busy), .tcam_sk(tcam_sk), .tcam_clr(tcam_clr), .tcam_we(tcam_we),
      .tcam_rules(tcam_rules), .tcam_match(tcam_match), .dbg_state(dbg_state)
   );

   // ---------------- behavioural fractional TCAM ----------------
   // Each group is a 2**KW x GROUP LUT addressed by sk; match is a plain read.
   logic [GROUP-1:0] lut [NGRP][1 << KW];
   logic scramble;

   always @(posedge wclk) begin
      for (int g = 0; g < NGRP; g++) begin
         if (scramble) begin
            for (int a = 0; a < (1 << KW); a++) lut[g][a] <= GROUP'($urandom);
         end else if (tcam_we[g]) begin
            lut[g][tcam_sk] <= tcam_rules;
         end
      end
   end

   always_comb begin
      tcam_match = '0;
      for (int g = 0; g < NGRP; g++)
         for (int j = 0; j < GROUP; j++)
            tcam_match[g * GROUP + j] = lut[g][tcam_sk][j];
   end

   // ---------------- reference model: list of rules ----------------
   logic          m_valid [DEPTH];
   logic [KW-1:0] m_key   [DEPTH];
   logic [KW-1:0] m_mask  [DEPTH];

   task automatic model_clear();
      for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
   endtask

   task automatic model_apply(input logic [1:0] op, input logic [IW-1:0] idx,
                              input logic [KW-1:0] key, input logic [KW-1:0] mask);
      if (op == OP_WRITE) begin
         m_valid[idx] = 1'b1; m_key[idx] = key; m_mask[idx] = mask;
      end else if (op == OP_DELETE) begin
         m_valid[idx] = 1'b0;
      end else if (op == OP_FLUSH) begin
         model_clear();
      end
   endtask

   // Returns {hit, idx}: first valid rule whose cared-about bits equal the key.
   function automatic logic [IW:0] model_lookup(input logic [KW-1:0] k);
      for (int e = 0; e < DEPTH; e++)
         if (m_valid[e] && ((k & m_mask[e]) == (m_key[e] & m_mask[e])))
            return {1'b1, IW'(e)};
      return '0;
   endfunction

   // ---------------- scoreboard / monitor state ----------------
   int n_tests, n_fail, cyc;
   logic [37:0] exp_q[$];   // {cycle of result, hit, idx}
   int mon_we_cyc, mon_rules_nz, mon_sk_err, mon_done;
   logic [NGRP-1:0]  mon_we_val;
   logic [KW-1:0]    mon_rules_sk, prev_sk;
   logic [GROUP-1:0] mon_rules_val;
   logic prev_we;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every wait in the bench goes through tick, so every cycle is observed.
   task automatic tick();
      logic [37:0] e;
      @(posedge wclk);
      #1;
      cyc++;
      if (tcam_we != '0) begin
         if (prev_we ? (tcam_sk != KW'(prev_sk + 1)) : (tcam_sk != '0)) mon_sk_err++;
         mon_we_cyc++;
         mon_we_val = tcam_we;
         if (tcam_rules != '0) begin
            mon_rules_nz++;
            mon_rules_sk  = tcam_sk;
            mon_rules_val = tcam_rules;
         end
      end
      prev_we = (tcam_we != '0);
      prev_sk = tcam_sk;
      if (upd_done) mon_done++;
      if (rslt_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rslt_unexpected: strobe at cycle %0d with no pending search", cyc);
         end else begin
            e = exp_q.pop_front();
            check("rslt_cycle", 64'(cyc), 64'(e[37:6]));
            check("rslt_hit_idx", {rslt_hit, rslt_idx}, e[5:0]);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_upd_ready();
      int w = 0;
      while (!upd_ready && w < 100) begin tick(); w++; end
      check("upd_ready_timeout", upd_ready, 1);
   endtask

   task automatic do_update(input logic [1:0] op, input logic [IW-1:0] idx,
                            input logic [KW-1:0] key, input logic [KW-1:0] mask,
                            output int lat);
      wait_upd_ready();
      upd_valid = 1'b1; upd_op = op; upd_idx = idx; upd_key = key; upd_mask = mask;
      tick();
      model_apply(op, idx, key, mask);
      upd_valid = 1'b0;
      upd_op = 2'($urandom); upd_idx = IW'($urandom);   // ignored while busy
      lat = 0;
      while (!upd_done && lat < 200) begin tick(); lat++; end
   endtask

   task automatic do_search(input logic [KW-1:0] key, input logic hit, input logic [IW-1:0] idx);
      int w = 0;
      while (!srch_ready && w < 100) begin tick(); w++; end
      check("srch_ready_timeout", srch_ready, 1);
      srch_valid = 1'b1;
      srch_key   = key;
      exp_q.push_back({32'(cyc + 2), hit, idx});
      tick();
      srch_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (4) tick();
      check("exp_q_empty", exp_q.size(), 0);
   endtask

   // Releases reset and checks the full flush sweep that follows.
   task automatic check_init(input string tag);
      int b_we, b_nz, b_err, b_done, n, busy_bad;
      b_we = mon_we_cyc; b_nz = mon_rules_nz; b_err = mon_sk_err; b_done = mon_done;
      n = 0; busy_bad = 0;
      rst_n = 1'b1;
      while (!upd_ready && n < 100) begin
         tick(); n++;
         if (!upd_ready && !busy) busy_bad++;
      end
      check({tag, "_ready_cycles"}, n, 32);
      check({tag, "_busy"}, busy_bad, 0);
      check({tag, "_we_cycles"}, mon_we_cyc - b_we, 32);
      check({tag, "_we_val"}, mon_we_val, 4'hF);
      check({tag, "_rules_zero"}, mon_rules_nz - b_nz, 0);
      check({tag, "_sk_seq"}, mon_sk_err - b_err, 0);
      check({tag, "_no_done"}, mon_done - b_done, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]    op;
      logic [IW-1:0] idx;
      logic [KW-1:0] key;
      logic [KW-1:0] mask;
      logic [KW-1:0] skey;
      logic          exp_hit;
      logic [IW-1:0] exp_idx;
   } vec_t;
   localparam int NV = 10;
   vec_t tbl [NV];

   initial begin
      int lat, n, b_we, b_nz, b_err, b_done, r;
      logic seen_done;
      logic [1:0] op;
      logic [KW-1:0] k;
      logic [IW:0] m;

      tbl[0] = '{OP_WRITE,  5'd3,  5'h00, 5'h00, 5'd21, 1'b1, 5'd3};
      tbl[1] = '{OP_NOP,    5'd0,  5'h00, 5'h00, 5'd7,  1'b1, 5'd3};
      tbl[2] = '{OP_DELETE, 5'd3,  5'h00, 5'h00, 5'd21, 1'b1, 5'd9};
      tbl[3] = '{OP_DELETE, 5'd3,  5'h00, 5'h00, 5'd20, 1'b0, 5'd0};
      tbl[4] = '{OP_WRITE,  5'd17, 5'h10, 5'h10, 5'd16, 1'b1, 5'd17};
      tbl[5] = '{OP_WRITE,  5'd30, 5'h1F, 5'h00, 5'd5,  1'b1, 5'd30};
      tbl[6] = '{OP_WRITE,  5'd9,  5'h00, 5'h1F, 5'd0,  1'b1, 5'd9};
      tbl[7] = '{OP_WRITE,  5'd2,  5'h03, 5'h03, 5'd7,  1'b1, 5'd2};
      tbl[8] = '{OP_FLUSH,  5'd12, 5'h00, 5'h00, 5'd21, 1'b0, 5'd0};
      tbl[9] = '{OP_NOP,    5'd0,  5'h00, 5'h00, 5'd0,  1'b0, 5'd0};

      n_tests = 0; n_fail = 0; cyc = 0;
      mon_we_cyc = 0; mon_rules_nz = 0; mon_sk_err = 0; mon_done = 0;
      mon_we_val = '0; mon_rules_sk = '0; mon_rules_val = '0; prev_we = 1'b0; prev_sk = '0;
      upd_valid = 1'b0; upd_op = OP_NOP; upd_idx = '0; upd_key = '0; upd_mask = '0;
      srch_valid = 1'b0; srch_key = '0;
      model_clear();

      // Reset with scrambled TCAM contents, then the init flush sweep.
      rst_n = 1'b0; scramble = 1'b1;
      repeat (3) tick();
      scramble = 1'b0;
      tick();
      check("reset_outputs", {upd_ready, srch_ready, upd_done, rslt_valid, rslt_hit, rslt_idx,
                              busy, tcam_sk, tcam_clr, tcam_we, tcam_rules}, '0);
      check("reset_state", dbg_state, S_INIT);
      check_init("init");
      check("idle_state", dbg_state, S_IDLE);

      // Single WRITE: one group's LUT, one matching address, 34-cycle latency.
      b_we = mon_we_cyc; b_nz = mon_rules_nz; b_err = mon_sk_err; b_done = mon_done;
      do_update(OP_WRITE, 5'd9, 5'h15, 5'h1F, lat);
      check("w9_latency", lat, 34);
      check("w9_we_cycles", mon_we_cyc - b_we, 32);
      check("w9_we_val", mon_we_val, 4'b0010);
      check("w9_rules_count", mon_rules_nz - b_nz, 1);
      check("w9_rules_sk", mon_rules_sk, 5'd21);
      check("w9_rules_val", mon_rules_val, 8'h02);
      check("w9_sk_seq", mon_sk_err - b_err, 0);
      check("w9_done_once", mon_done - b_done, 1);
      check("w9_done_pulse", {upd_done, busy}, 2'b10);
      tick();
      check("w9_done_drop", upd_done, 0);

      // Table-driven update + lookup vectors.
      for (int i = 0; i < NV; i++) begin
         do_update(tbl[i].op, tbl[i].idx, tbl[i].key, tbl[i].mask, lat);
         check("tbl_latency", lat, (tbl[i].op == OP_NOP) ? 1 : 34);
         do_search(tbl[i].skey, tbl[i].exp_hit, tbl[i].exp_idx);
      end
      drain();

      // After FLUSH every key misses; issued back to back.
      for (int i = 0; i < (1 << KW); i++) do_search(KW'(i), 1'b0, '0);
      drain();

      // Simultaneous update and search: update wins, search held off until idle.
      wait_upd_ready();
      upd_valid = 1'b1; upd_op = OP_WRITE; upd_idx = 5'd2; upd_key = 5'h02; upd_mask = 5'h1E;
      srch_valid = 1'b1; srch_key = 5'd2;
      #1;
      check("sim_srch_ready", srch_ready, 0);
      check("sim_upd_ready", upd_ready, 1);
      tick();
      model_apply(OP_WRITE, 5'd2, 5'h02, 5'h1E);
      upd_valid = 1'b0;
      n = 0; seen_done = 1'b0;
      while (!srch_ready && n < 200) begin
         tick(); n++;
         if (upd_done) seen_done = 1'b1;
      end
      srch_valid = 1'b0;
      check("sim_blocked_cycles", n, 34);
      check("sim_done_seen", seen_done, 1);

      // Back-to-back lookups: one result per cycle, two-edge latency each.
      do_search(5'd1, 1'b0, 5'd0);
      do_search(5'd2, 1'b1, 5'd2);
      do_search(5'd3, 1'b1, 5'd2);
      drain();

      // Randomized updates and lookups against the rule-list model.
      for (int t = 0; t < 10; t++) begin
         r = $urandom_range(0, 19);
         op = (r < 12) ? OP_WRITE : (r < 17) ? OP_DELETE : (r < 19) ? OP_NOP : OP_FLUSH;
         do_update(op, IW'($urandom), KW'($urandom), KW'($urandom_range(0, 31)), lat);
         check("rnd_latency", lat, (op == OP_NOP) ? 1 : 34);
         repeat ($urandom_range(3, 8)) begin
            k = KW'($urandom);
            m = model_lookup(k);
            do_search(k, m[IW], m[IW-1:0]);
         end
      end
      drain();

      // Reset in the middle of a sweep restarts the init flush from sk=0.
      wait_upd_ready();
      upd_valid = 1'b1; upd_op = OP_WRITE; upd_idx = 5'd20; upd_key = 5'h0A; upd_mask = 5'h1F;
      tick();
      upd_valid = 1'b0;
      n = 0;
      while (!(tcam_we != '0 && tcam_sk == 5'd10) && n < 100) begin tick(); n++; end
      check("mid_sweep_reached", tcam_sk, 5'd10);
      rst_n = 1'b0;
      tick();
      tick();
      check("mid_reset_outputs", {upd_ready, upd_done, busy, tcam_sk, tcam_we, tcam_rules}, '0);
      model_clear();
      check_init("mid_init");
      do_search(5'd10, 1'b0, 5'd0);
      m = model_lookup(5'd21);
      do_search(5'd21, m[IW], m[IW-1:0]);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
